dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter and sequencer for the single-port data memory behind the MIPS MEM stage. It shares the memory between the pipeline (stage_mem load/store traffic) and a debug/loader port used to preload and dump memory. The pipeline has priority. A starvation counter guarantees the debug port a slot, and a halt mode freezes the pipeline so debug owns every slot. The block sits between stage_mem and the data-memory array; its stall output goes to the pipeline hazard logic.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 10, word-address width (memory depth 2^ADDR_W words)
- MAX_WAIT, 8, cycles a pending debug request may be refused before it is forced through (1..2^WAIT_W-1)
- WAIT_W, 4, width of the starvation counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- memReadIn  in  1  pipeline load request this cycle
- memWriteIn  in  1  pipeline store request this cycle
- aluResultIn  in  32  pipeline word address; low ADDR_W bits used
- writeDataIn  in  DATA_W  pipeline store data
- readDataOut  out  DATA_W  pipeline load data, valid the cycle after the grant
- stallOut  out  1  pipeline must hold MEM stage this cycle
- dbgReq  in  1  debug access request; held until dbgAck
- dbgWe  in  1  1 = write, 0 = read; stable while dbgReq
- dbgAddr  in  ADDR_W  debug word address
- dbgWdata  in  DATA_W  debug write data
- dbgAck  out  1  one-cycle pulse: debug access issued to memory
- dbgRvalid  out  1  one-cycle pulse, cycle after a debug read ack
- dbgRdata  out  DATA_W  debug read data, valid with dbgRvalid
- dbgHalt  in  1  level: request pipeline freeze
- haltedOut  out  1  1 while in HALT state
- memAddr  out  ADDR_W  to memory array
- memWdata  out  DATA_W  to memory array
- memWe  out  1  memory write strobe
- memRe  out  1  memory read strobe
- memRdata  in  DATA_W  memory read data, 1-cycle synchronous latency

## Operation
- A pipeline access is pipeReq = memReadIn | memWriteIn. If both are 1, it is treated as a write.
- The FSM has two states, RUN and HALT.
- RUN grant rule, evaluated combinationally each cycle:
  - If waitCnt == MAX_WAIT and dbgReq, grant debug. If pipeReq is also 1, stallOut = 1.
  - Otherwise, if pipeReq, grant the pipeline. stallOut = 0.
  - Otherwise, if dbgReq, grant debug.
  - Otherwise, no grant: memWe = memRe = 0.
- waitCnt (WAIT_W bits) behaviour:
  - Increments each cycle dbgReq = 1 and debug is not granted.
  - Clears on any debug grant or when dbgReq = 0.
  - Saturates at MAX_WAIT.
- HALT state:
  - stallOut = 1 every cycle.
  - Debug is granted whenever dbgReq. The pipeline is never granted.
  - waitCnt is held at 0.
- Transitions:
  - RUN->HALT at the edge where dbgHalt = 1.
  - HALT->RUN at the edge where dbgHalt = 0.
  - haltedOut = (state == HALT).
- The grant drives memAddr/memWdata/memWe/memRe from the granted source. With no grant, memAddr = 0 and memWdata = 0.
- dbgAck = 1 in the cycle debug is granted.
- A registered owner bit (rdOwner) and rdPend record who issued a read. Next cycle:
  - If rdOwner = debug, dbgRvalid = 1 and dbgRdata = memRdata.
  - If rdOwner = pipe, readDataOut = memRdata.
  - When no pipeline read is pending, readDataOut holds its last value.

## Timing
- Reset values: state = RUN, waitCnt = 0, rdPend = 0, readDataOut = 0, dbgRdata = 0, dbgRvalid = 0, haltedOut = 0.
- Combinational outputs evaluated with reset = 1: no grant, dbgAck = 0, stallOut = 0.
- Latency:
  - Writes complete at the grant edge.
  - Read data appears exactly 1 cycle after the grant, for both requesters.
- A debug request is served in at most MAX_WAIT+1 cycles from dbgReq rising in RUN.
- In a forced slot, the pipeline holds its inputs (stallOut = 1) and is granted the following cycle. The forced slot costs exactly one stall cycle.
- dbgHalt rising while a pipeline read is in flight: the read's data still returns to readDataOut next cycle.
- Reset mid-operation: a pending read is discarded (no dbgRvalid), and an outstanding dbgReq restarts arbitration from waitCnt = 0.

## Test plan
- Pipeline store then load:
  - Stimulus: memWriteIn = 1, addr 3, data 9 for one cycle; then memReadIn = 1, addr 3.
  - Response: stallOut = 0 throughout; readDataOut = 9 one cycle after the load grant.
- Idle-bus debug access:
  - Stimulus: pipeReq = 0; dbgReq write addr 30, data 99; then a debug read of addr 30.
  - Response: dbgAck in the same cycle as each request; dbgRvalid with dbgRdata = 99 one cycle after the read ack.
- Starvation, MAX_WAIT = 8:
  - Stimulus: pipeline loads every cycle; dbgReq read of addr 300 (preloaded 999) raised at cycle 0.
  - Response: dbgAck and stallOut = 1 in cycle 8 only; dbgRdata = 999 in cycle 9; pipeline granted again in cycle 9.
- Halt:
  - Stimulus: raise dbgHalt; issue debug writes to addrs 0..3; drop dbgHalt.
  - Response: haltedOut = 1 from the next cycle; stallOut = 1 each halted cycle; four acks; memory reads back the written values; pipeline resumes one cycle after dbgHalt falls.
- Simultaneous read and write flags:
  - Stimulus: memReadIn = memWriteIn = 1, addr 5, data 7.
  - Response: memWe = 1 and memRe = 0 that cycle; a later read of addr 5 returns 7.
- Reset mid-read:
  - Stimulus: debug read acked at cycle N; reset = 1 at cycle N+1.
  - Response: no dbgRvalid; all registered outputs return to reset values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MIPS MEM
// stage (priority requester) and a debug/loader port. A starvation counter
// forces a debug slot after MAX_WAIT refusals, and a HALT state freezes the
// pipeline so that debug owns every memory slot.
//
// Handshakes: the pipeline has no ready. stallOut=1 means "this cycle's
// access was not taken, hold the MEM stage". The debug port keeps dbgReq
// high with stable dbgWe/dbgAddr/dbgWdata until it sees the one-cycle
// dbgAck pulse, which marks the cycle the access is issued to memory.
// Read data returns one cycle after the grant. Pipeline read data appears on
// readDataOut. Debug read data appears on dbgRdata qualified by dbgRvalid.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memReadIn,
  input  logic              memWriteIn,
  input  logic [31:0]       aluResultIn,
  input  logic [DATA_W-1:0] writeDataIn,
  output logic [DATA_W-1:0] readDataOut,
  output logic              stallOut,
  input  logic              dbgReq,
  input  logic              dbgWe,
  input  logic [ADDR_W-1:0] dbgAddr,
  input  logic [DATA_W-1:0] dbgWdata,
  output logic              dbgAck,
  output logic              dbgRvalid,
  output logic [DATA_W-1:0] dbgRdata,
  input  logic              dbgHalt,
  output logic              haltedOut,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic              memWe,
  output logic              memRe,
  input  logic [DATA_W-1:0] memRdata
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_owner_q, rd_owner_d;   // 1 = debug issued the read
  logic [DATA_W-1:0]   pipe_hold_q;
  logic [DATA_W-1:0]   dbg_hold_q;

  logic                pipe_req;
  logic                forced;
  logic                grant_pipe;
  logic                grant_dbg;
  logic                pipe_rd_valid;
  logic                dbg_rd_valid;

  // Only the word-address bits reach the array.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^aluResultIn[31:ADDR_W];

  // A request with both flags set is a store.
  assign pipe_req = memReadIn | memWriteIn;

  // Grant decision: forced debug slot, then pipeline, then idle-bus debug.
  // Reset suppresses every grant so nothing reaches memory during reset.
  always_comb begin
    forced     = 1'b0;
    grant_pipe = 1'b0;
    grant_dbg  = 1'b0;
    stallOut   = 1'b0;
    if (!reset) begin
      if (state_q == ST_HALT) begin
        grant_dbg = dbgReq;
        stallOut  = 1'b1;
      end else begin
        forced = dbgReq && (wait_q == MAX_WAIT_C);
        if (forced) begin
          grant_dbg = 1'b1;
          stallOut  = pipe_req;
        end else if (pipe_req) begin
          grant_pipe = 1'b1;
        end else if (dbgReq) begin
          grant_dbg = 1'b1;
        end
      end
    end
  end

  // Steer the granted source onto the memory port; zeros when idle.
  always_comb begin
    memAddr  = '0;
    memWdata = '0;
    memWe    = 1'b0;
    memRe    = 1'b0;
    if (grant_pipe) begin
      memAddr  = aluResultIn[ADDR_W-1:0];
      memWdata = writeDataIn;
      memWe    = memWriteIn;
      memRe    = ~memWriteIn;
    end else if (grant_dbg) begin
      memAddr  = dbgAddr;
      memWdata = dbgWdata;
      memWe    = dbgWe;
      memRe    = ~dbgWe;
    end
  end

  assign dbgAck = grant_dbg;

  // Next-state: halt follows dbgHalt, the starvation counter counts refused
  // debug cycles in RUN and saturates, and read ownership is recorded.
  always_comb begin
    state_d    = dbgHalt ? ST_HALT : ST_RUN;
    wait_d     = '0;
    if (state_q == ST_RUN && dbgReq && !grant_dbg) begin
      wait_d = (wait_q == MAX_WAIT_C) ? wait_q : wait_q + WAIT_W'(1);
    end
    rd_pend_d  = (grant_pipe && !memWriteIn) || (grant_dbg && !dbgWe);
    rd_owner_d = grant_dbg;
  end

  // Returned data is steered by the owner recorded at grant time. Reset
  // discards a read that is in flight.
  assign pipe_rd_valid = rd_pend_q && !rd_owner_q && !reset;
  assign dbg_rd_valid  = rd_pend_q &&  rd_owner_q && !reset;

  assign readDataOut = pipe_rd_valid ? memRdata : pipe_hold_q;
  assign dbgRvalid   = dbg_rd_valid;
  assign dbgRdata    = dbg_rd_valid ? memRdata : dbg_hold_q;
  assign haltedOut   = (state_q == ST_HALT);

  // State registers, including the hold registers that keep the last data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      pipe_hold_q <= '0;
      dbg_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      if (pipe_rd_valid) pipe_hold_q <= memRdata;
      if (dbg_rd_valid)  dbg_hold_q  <= memRdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          memReadIn = 1'b0, memWriteIn = 1'b0;
  logic [31:0]   aluResultIn = '0;
  logic [DW-1:0] writeDataIn = '0;
  logic [DW-1:0] readDataOut;
  logic          stallOut;
  logic          dbgReq = 1'b0, dbgWe = 1'b0;
  logic [AW-1:0] dbgAddr = '0;
  logic [DW-1:0] dbgWdata = '0;
  logic          dbgAck, dbgRvalid;
  logic [DW-1:0] dbgRdata;
  logic          dbgHalt = 1'b0;
  logic          haltedOut;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic          memWe, memRe;
  logic [DW-1:0] memRdata = '0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .aluResultIn(aluResultIn), .writeDataIn(writeDataIn),
    .readDataOut(readDataOut), .stallOut(stallOut),
    .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata),
    .dbgAck(dbgAck), .dbgRvalid(dbgRvalid), .dbgRdata(dbgRdata),
    .dbgHalt(dbgHalt), .haltedOut(haltedOut),
    .memAddr(memAddr), .memWdata(memWdata), .memWe(memWe), .memRe(memRe),
    .memRdata(memRdata)
  );

  // Memory array the arbiter drives: 1-cycle synchronous read.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (memWe) env_mem[memAddr] <= memWdata;
    if (memRe) memRdata <= env_mem[memAddr];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what memory should contain, which reads are owed to
  // whom, how long the debug request has been refused, and halt status.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] pipe_exp_q[$];
  logic [DW-1:0] dbg_exp_q[$];
  logic [DW-1:0] last_pipe = '0, last_dbg = '0;
  int            m_wait = 0;
  bit            m_halt = 1'b0;

  bit            e_gp, e_gd, e_stall, e_dvalid, e_forced;
  logic [AW-1:0] e_addr, p_addr;
  logic [DW-1:0] e_wdata;
  bit            e_we, e_re;

  // Compare process: evaluate the rules for this cycle, compare, then
  // advance the model to what the coming clock edge should produce.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_stall", stallOut, 0);
      chk("rst_ack", dbgAck, 0);
      chk("rst_we", memWe, 0);
      chk("rst_re", memRe, 0);
      chk("rst_addr", memAddr, 0);
      chk("rst_rvalid", dbgRvalid, 0);
      pipe_exp_q.delete();
      dbg_exp_q.delete();
      last_pipe = '0;
      last_dbg  = '0;
      m_wait    = 0;
      m_halt    = 1'b0;
    end else begin
      p_addr = aluResultIn[AW-1:0];
      e_gp = 0; e_gd = 0; e_stall = 0;
      if (m_halt) begin
        e_gd = dbgReq; e_stall = 1;
      end else begin
        e_forced = dbgReq && (m_wait >= MW);
        e_gd     = e_forced || (dbgReq && !(memReadIn || memWriteIn));
        e_gp     = (memReadIn || memWriteIn) && !e_forced;
        e_stall  = e_forced && (memReadIn || memWriteIn);
      end
      e_addr = '0; e_wdata = '0; e_we = 0; e_re = 0;
      if (e_gp) begin
        e_addr = p_addr; e_wdata = writeDataIn; e_we = memWriteIn; e_re = !memWriteIn;
      end else if (e_gd) begin
        e_addr = dbgAddr; e_wdata = dbgWdata; e_we = dbgWe; e_re = !dbgWe;
      end
      if (pipe_exp_q.size() > 0) last_pipe = pipe_exp_q.pop_front();
      e_dvalid = dbg_exp_q.size() > 0;
      if (e_dvalid) last_dbg = dbg_exp_q.pop_front();

      chk("stall", stallOut, e_stall);
      chk("ack", dbgAck, e_gd);
      chk("mem_we", memWe, e_we);
      chk("mem_re", memRe, e_re);
      chk("mem_addr", memAddr, e_addr);
      chk("mem_wdata", memWdata, e_wdata);
      chk("halted", haltedOut, m_halt);
      chk("rvalid", dbgRvalid, e_dvalid);
      chk("rdata", dbgRdata, last_dbg);
      chk("read_data", readDataOut, last_pipe);

      if (e_re && e_gp) pipe_exp_q.push_back(shadow[e_addr]);
      if (e_re && e_gd) dbg_exp_q.push_back(shadow[e_addr]);
      if (e_we) shadow[e_addr] = e_wdata;
      if (m_halt || !dbgReq || e_gd) m_wait = 0;
      else if (m_wait < MW) m_wait = m_wait + 1;
      m_halt = dbgHalt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    memReadIn = 0; memWriteIn = 0; dbgReq = 0; dbgWe = 0;
  endtask

  // ---------------- stimulus ----------------
  int  ack_c, stalls, acks;
  bit  dbg_act, got_ack;
  int  p;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = DW'(i * 7);
      shadow[i]  = DW'(i * 7);
    end
    env_mem[300] = 999;
    shadow[300]  = 999;

    tick(); tick();
    reset = 0;
    mid();
    chk("post_rst_halted", haltedOut, 0);
    chk("post_rst_rdout", readDataOut, 0);
    chk("post_rst_dbgrdata", dbgRdata, 0);
    tick();

    // Pipeline store then load.
    memWriteIn = 1; aluResultIn = 3; writeDataIn = 9;
    mid(); chk("st_stall", stallOut, 0); chk("st_we", memWe, 1);
    tick();
    memWriteIn = 0; memReadIn = 1; aluResultIn = 3;
    mid(); chk("ld_stall", stallOut, 0); chk("ld_re", memRe, 1);
    tick();
    idle();
    mid(); chk("ld_data", readDataOut, 9);
    tick();

    // Idle-bus debug write then read.
    dbgReq = 1; dbgWe = 1; dbgAddr = 30; dbgWdata = 99;
    mid(); chk("dbg_wr_ack", dbgAck, 1);
    tick();
    dbgWe = 0;
    mid(); chk("dbg_rd_ack", dbgAck, 1);
    tick();
    idle();
    mid(); chk("dbg_rvalid", dbgRvalid, 1); chk("dbg_rdata", dbgRdata, 99);
    tick();

    // Starvation: pipeline loads every cycle, debug read of addr 300.
    memReadIn = 1; dbgReq = 1; dbgWe = 0; dbgAddr = 300;
    ack_c = -1; stalls = 0;
    for (int c = 0; c < 10; c++) begin
      aluResultIn = 32'(10 + c);
      if (ack_c >= 0) dbgReq = 0;
      mid();
      if (dbgAck && ack_c < 0) ack_c = c;
      if (stallOut) stalls++;
      if (c == 9) begin
        chk("starve_rvalid", dbgRvalid, 1);
        chk("starve_rdata", dbgRdata, 999);
        chk("starve_pipe_re", memRe, 1);
        chk("starve_pipe_addr", memAddr, 19);
      end
      tick();
    end
    chk("starve_ack_cycle", ack_c, 8);
    chk("starve_stalls", stalls, 1);
    idle();

    // Simultaneous read and write flags act as a store.
    memReadIn = 1; memWriteIn = 1; aluResultIn = 5; writeDataIn = 7;
    mid(); chk("both_we", memWe, 1); chk("both_re", memRe, 0);
    tick();
    memWriteIn = 0;
    mid();
    tick();
    idle();
    mid(); chk("both_readback", readDataOut, 7);
    tick();

    // Halt: debug writes while the pipeline keeps requesting.
    dbgHalt = 1;
    tick();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      memReadIn = 1; aluResultIn = 32'(40 + i);
      dbgReq = 1; dbgWe = 1; dbgAddr = AW'(i); dbgWdata = 32'(100 + i);
      mid();
      chk("halt_halted", haltedOut, 1);
      chk("halt_stall", stallOut, 1);
      if (dbgAck) acks++;
      tick();
    end
    chk("halt_acks", acks, 4);
    dbgReq = 0; dbgHalt = 0;
    mid(); chk("unhalt_stall", stallOut, 1); chk("unhalt_re", memRe, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin memReadIn = 1; aluResultIn = 32'(i); end
      else memReadIn = 0;
      mid();
      if (i == 0) begin
        chk("resume_halted", haltedOut, 0);
        chk("resume_stall", stallOut, 0);
        chk("resume_re", memRe, 1);
      end else begin
        chk("halt_readback", readDataOut, 32'(100 + i - 1));
      end
      tick();
    end
    idle();

    // Reset while a debug read is in flight.
    dbgReq = 1; dbgWe = 0; dbgAddr = 30;
    mid(); chk("rr_ack", dbgAck, 1);
    tick();
    reset = 1;
    mid(); chk("rr_rvalid_in_rst", dbgRvalid, 0); chk("rr_ack_in_rst", dbgAck, 0);
    tick();
    reset = 0;
    mid();
    chk("rr_rvalid_after", dbgRvalid, 0);
    chk("rr_halted_after", haltedOut, 0);
    chk("rr_rdout_after", readDataOut, 0);
    chk("rr_dbgrdata_after", dbgRdata, 0);
    tick();
    idle();
    tick();

    // Randomized traffic with the debug hold-until-ack protocol.
    dbg_act = 0; got_ack = 0;
    for (int c = 0; c < 3000; c++) begin
      if (got_ack) dbg_act = 0;
      if (!dbg_act && $urandom_range(0, 3) == 0) begin
        dbg_act  = 1;
        dbgWe    = $urandom_range(0, 1);
        dbgAddr  = AW'($urandom_range(0, 15));
        dbgWdata = $urandom;
      end
      dbgReq      = dbg_act;
      p           = ((c / 300) % 2 == 1) ? 10 : 5;
      memReadIn   = $urandom_range(0, 9) < p;
      memWriteIn  = $urandom_range(0, 3) == 0;
      aluResultIn = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
      writeDataIn = $urandom;
      if ($urandom_range(0, 99) == 0) dbgHalt = !dbgHalt;
      reset = ($urandom_range(0, 999) == 0);
      mid();
      got_ack = dbgAck;
      tick();
    end
    reset = 0;
    idle();
    dbgHalt = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
